// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operand/mode request with a ready/valid
// strobe, and the registered result, flags and status pulses coming back.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [3:0]       mode;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_hi;
    logic             out_valid;
    logic [3:0]       flags;
    logic             flags_updated;
    logic             err;

    modport master (
        output in_valid, operand1, operand2, mode,
        input  in_ready, out, out_hi, out_valid, flags, flags_updated, err
    );

    modport slave (
        input  in_valid, operand1, operand2, mode,
        output in_ready, out, out_hi, out_valid, flags, flags_updated, err
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic/shift ops plus an iterative
// shift-add multiplier that takes one partial-product bit per cycle.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    localparam logic [WIDTH-1:0] LAST_STEP = WIDTH'(WIDTH - 1);
    localparam logic [WIDTH:0]   WIDTH_AMT = (WIDTH + 1)'(WIDTH);

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] step_cnt;

    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] out_hi_r;
    logic [3:0]       flags_r;
    logic             out_valid_r;
    logic             flags_updated_r;
    logic             err_r;

    logic             accept;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             legal;
    logic             big_shift;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] next_hi;
    logic [WIDTH-1:0] next_lo;

    assign a      = bus.operand1;
    assign b      = bus.operand2;
    assign accept = bus.in_valid && bus.in_ready;

    assign bus.in_ready      = (state == IDLE);
    assign bus.out           = out_r;
    assign bus.out_hi        = out_hi_r;
    assign bus.flags         = flags_r;
    assign bus.out_valid     = out_valid_r;
    assign bus.flags_updated = flags_updated_r;
    assign bus.err           = err_r;

    // Shifts run one bit wider so the last bit shifted out lands in the extra position.
    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        legal     = 1'b1;
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        shl_ext   = {1'b0, a} << b;
        shr_ext   = {a, 1'b0} >> b;
        big_shift = ({1'b0, b} >= WIDTH_AMT);
        case (bus.mode)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_NOT: alu_res = ~a;
            OP_XOR: alu_res = a ^ b;
            OP_SHL: begin
                alu_res = big_shift ? '0 : shl_ext[WIDTH-1:0];
                alu_c   = !big_shift && shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_res = big_shift ? '0 : shr_ext[WIDTH:1];
                alu_c   = !big_shift && shr_ext[0];
            end
            OP_MUL: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // One multiplier step: conditionally add the multiplicand, then shift {hi,lo} right.
    always_comb begin
        step_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        next_hi  = step_sum[WIDTH:1];
        next_lo  = {step_sum[0], acc_lo[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            mcand           <= '0;
            acc_hi          <= '0;
            acc_lo          <= '0;
            step_cnt        <= '0;
            out_r           <= '0;
            out_hi_r        <= '0;
            flags_r         <= '0;
            out_valid_r     <= 1'b0;
            flags_updated_r <= 1'b0;
            err_r           <= 1'b0;
        end else begin
            out_valid_r     <= 1'b0;
            flags_updated_r <= 1'b0;
            err_r           <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.mode == OP_MUL) begin
                            state    <= MUL;
                            mcand    <= a;
                            acc_hi   <= '0;
                            acc_lo   <= b;
                            step_cnt <= '0;
                        end else if (legal) begin
                            out_r           <= alu_res;
                            out_hi_r        <= '0;
                            flags_r         <= {alu_v, alu_res[WIDTH-1], (alu_res == '0), alu_c};
                            out_valid_r     <= 1'b1;
                            flags_updated_r <= 1'b1;
                        end else begin
                            out_r       <= '0;
                            out_hi_r    <= '0;
                            out_valid_r <= 1'b1;
                            err_r       <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_hi   <= next_hi;
                    acc_lo   <= next_lo;
                    step_cnt <= step_cnt + 1'b1;
                    if (step_cnt == LAST_STEP) begin
                        state           <= IDLE;
                        out_r           <= next_lo;
                        out_hi_r        <= next_hi;
                        flags_r         <= {1'b0, next_lo[WIDTH-1], (next_lo == '0), (next_hi != '0)};
                        out_valid_r     <= 1'b1;
                        flags_updated_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits, legal range 4..32.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Rst_n  input  1  asynchronous, active-low reset; assertion clears state immediately, release takes effect synchronously to Clk.
REQ-004 In_valid  input  1  request strobe; operands and mode sampled when In_valid && In_ready at a rising edge.
REQ-005 In_ready  output  1  high only in IDLE; low throughout a multiply.
REQ-006 Operand1  input  WIDTH  first operand, unsigned (signed for the V flag).
REQ-007 Operand2  input  WIDTH  second operand; shift amount for SHL/SHR.
REQ-008 Mode  input  4  opcode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 NOT (~Operand1), 0101 XOR, 0110 SHL, 0111 SHR (logical), 1000 MUL; 1001..1111 illegal.
REQ-009 Out  output  WIDTH  registered result; MUL low half.
REQ-010 Out_hi  output  WIDTH  registered MUL high half; 0 for all other modes.
REQ-011 Out_valid  output  1  one-cycle pulse marking Out/Out_hi/Flags valid; no back-pressure.
REQ-012 Flags  output  4  registered {V,N,Z,C}; sticky between updates.
REQ-013 Flags_updated  output  1  one-cycle pulse, coincident with Out_valid, when Flags were rewritten.
REQ-014 Err  output  1  one-cycle pulse, coincident with Out_valid, for an illegal Mode.

Function
REQ-015 States IDLE and MUL only; IDLE->MUL on accept with Mode=MUL; MUL->IDLE after the final iteration; all other accepts stay in IDLE.
REQ-016 Non-MUL op: result, Flags, Out_valid registered on the accept edge; Out_valid high the following cycle; throughput one op per cycle (back-to-back accepts legal).
REQ-017 MUL: iterative shift-add, one partial-product bit per cycle, WIDTH-bit counter; Out_valid asserts exactly WIDTH cycles after the accept edge; In_ready returns high in that same cycle.
REQ-018 In_valid while In_ready=0 is ignored; operands captured at accept and held internally, so input changes during MUL do not affect the result.
REQ-019 ADD/SUB: Out = (Operand1 +/- Operand2) mod 2^WIDTH; C = carry-out (ADD) or borrow, i.e. Operand1 < Operand2 unsigned (SUB); V = two's-complement overflow.
REQ-020 AND/OR/XOR/NOT: C=0, V=0.
REQ-021 SHL/SHR: shift by Operand2; C = last bit shifted out; Operand2=0 -> Out=Operand1, C=0; Operand2 >= WIDTH -> Out=0, C=0; V=0.
REQ-022 MUL: {Out_hi,Out} = Operand1*Operand2 unsigned, 2*WIDTH bits; C=1 iff Out_hi != 0; V=0.
REQ-023 All legal modes: Z = (Out==0), N = Out[WIDTH-1] (Out_hi excluded); Flags_updated=1.
REQ-024 Illegal mode: Out=0, Out_hi=0, Flags unchanged, Flags_updated=0, Err=1, Out_valid=1, latency as REQ-016.
REQ-025 Out, Out_hi, Flags hold their last values when Out_valid=0.

Reset
REQ-026 Rst_n low: state=IDLE, multiply counter/accumulator cleared, Out=0, Out_hi=0, Flags=0, Out_valid=0, Flags_updated=0, Err=0; In_ready=1 in the first cycle after release.
REQ-027 Reset during MUL aborts it; no Out_valid is produced for the aborted operation.

Verification
REQ-028 WIDTH=8, ADD 0xFF+0x01 -> next cycle Out=0x00, Flags C=1 Z=1 N=0 V=0, Out_valid/Flags_updated pulse once.
REQ-029 SUB 0x80-0x01 -> Out=0x7F, V=1, C=0, N=0; then SUB 0x00-0x01 -> Out=0xFF, C=1, N=1.
REQ-030 MUL 0x10*0x10 -> In_ready low 8 cycles, Out_valid 8 cycles after accept, Out=0x00, Out_hi=0x01, C=1, Z=1; In_valid with new operands mid-MUL ignored.
REQ-031 SHL 0x81 by 1 -> Out=0x02, C=1; SHR 0x81 by 8 -> Out=0x00, C=0, Z=1.
REQ-032 Mode=1111 after an ADD -> Out=0, Err=1, Flags_updated=0, Flags equal ADD result.
REQ-033 Rst_n low 3 cycles after MUL accept -> all outputs zero immediately, no Out_valid, In_ready=1 after release; next ADD 0x02+0x03 -> Out=0x05.
